// File: rtl/countdown_timer_mmss.sv
// MM:SS BCD countdown timer (00:00..59:59) with a run/pause/alarm controller.
// Shares the 1 Hz Tick enable and the active-low Clr line with the clock counters.
module countdown_timer_mmss #(
  parameter int unsigned RING_TICKS = 10
) (
  input  logic       Clk,
  input  logic       Clr,
  input  logic       Tick,
  input  logic       LD,
  input  logic [2:0] IN_MT,
  input  logic [3:0] IN_MU,
  input  logic [2:0] IN_ST,
  input  logic [3:0] IN_SU,
  input  logic       Start,
  input  logic       Stop,
  output logic [2:0] MT,
  output logic [3:0] MU,
  output logic [2:0] ST,
  output logic [3:0] SU,
  output logic       Running,
  output logic       Alarm
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, RING} state_t;

  localparam logic [7:0] RingLast = 8'(RING_TICKS);

  state_t     r_state;
  logic [7:0] r_ringCnt;

  logic [2:0] w_ldMt, w_ldSt, w_decMt, w_decSt;
  logic [3:0] w_ldMu, w_ldSu, w_decMu, w_decSu;
  logic       w_borrowSu, w_borrowSt, w_borrowMu;
  logic       w_nonZero, w_decZero;
  logic [7:0] w_ringNext;

  // Out-of-range preset digits saturate to the largest legal digit.
  assign w_ldMt = (IN_MT > 3'd5) ? 3'd5 : IN_MT;
  assign w_ldMu = (IN_MU > 4'd9) ? 4'd9 : IN_MU;
  assign w_ldSt = (IN_ST > 3'd5) ? 3'd5 : IN_ST;
  assign w_ldSu = (IN_SU > 4'd9) ? 4'd9 : IN_SU;

  assign w_borrowSu = (SU == 4'd0);
  assign w_decSu    = w_borrowSu ? 4'd9 : SU - 4'd1;
  assign w_borrowSt = w_borrowSu && (ST == 3'd0);
  assign w_decSt    = w_borrowSu ? ((ST == 3'd0) ? 3'd5 : ST - 3'd1) : ST;
  assign w_borrowMu = w_borrowSt && (MU == 4'd0);
  assign w_decMu    = w_borrowSt ? ((MU == 4'd0) ? 4'd9 : MU - 4'd1) : MU;
  assign w_decMt    = w_borrowMu ? MT - 3'd1 : MT;

  assign w_nonZero  = |{MT, MU, ST, SU};
  assign w_decZero  = ~|{w_decMt, w_decMu, w_decSt, w_decSu};
  assign w_ringNext = r_ringCnt + 8'd1;

  // RUN is only entered with a nonzero value and leaves on reaching 00:00,
  // so the decrement can never wrap below zero.
  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      r_state   <= IDLE;
      r_ringCnt <= 8'd0;
      MT        <= 3'd0;
      MU        <= 4'd0;
      ST        <= 3'd0;
      SU        <= 4'd0;
      Running   <= 1'b0;
      Alarm     <= 1'b0;
    end else begin
      case (r_state)
        IDLE, PAUSE: begin
          if (LD) begin
            MT <= w_ldMt;
            MU <= w_ldMu;
            ST <= w_ldSt;
            SU <= w_ldSu;
          end else if (Stop) begin
            r_state <= r_state;
          end else if (Start && w_nonZero) begin
            r_state <= RUN;
            Running <= 1'b1;
          end
        end
        RUN: begin
          if (Stop) begin
            r_state <= PAUSE;
            Running <= 1'b0;
          end else if (Tick) begin
            MT <= w_decMt;
            MU <= w_decMu;
            ST <= w_decSt;
            SU <= w_decSu;
            if (w_decZero) begin
              r_state   <= RING;
              Running   <= 1'b0;
              Alarm     <= 1'b1;
              r_ringCnt <= 8'd0;
            end
          end
        end
        RING: begin
          if (LD) begin
            MT      <= w_ldMt;
            MU      <= w_ldMu;
            ST      <= w_ldSt;
            SU      <= w_ldSu;
            r_state <= IDLE;
            Alarm   <= 1'b0;
          end else if (Stop) begin
            r_state <= IDLE;
            Alarm   <= 1'b0;
          end else if (Tick) begin
            r_ringCnt <= w_ringNext;
            if (w_ringNext == RingLast) begin
              r_state <= IDLE;
              Alarm   <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          Running <= 1'b0;
          Alarm   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_countdown_timer_mmss.sv
// Directed self-checking bench for countdown_timer_mmss (RING_TICKS=3).
// Inputs change #1 after a rising edge; outputs are sampled at the same point.
module tb_countdown_timer_mmss;

  logic       Clk, Clr, Tick, LD, Start, Stop;
  logic [2:0] IN_MT, IN_ST, MT, ST;
  logic [3:0] IN_MU, IN_SU, MU, SU;
  logic       Running, Alarm;

  int checks   = 0;
  int failures = 0;

  countdown_timer_mmss #(.RING_TICKS(3)) dut (
    .Clk(Clk), .Clr(Clr), .Tick(Tick), .LD(LD),
    .IN_MT(IN_MT), .IN_MU(IN_MU), .IN_ST(IN_ST), .IN_SU(IN_SU),
    .Start(Start), .Stop(Stop),
    .MT(MT), .MU(MU), .ST(ST), .SU(SU),
    .Running(Running), .Alarm(Alarm)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [13:0] bcd(input int mt, input int mu, input int st, input int su);
    return {3'(mt), 4'(mu), 3'(st), 4'(su)};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkState(input string tag, input logic [13:0] digits, input logic run, input logic alarm);
    checkOutput({tag, ".digits"}, 32'({MT, MU, ST, SU}), 32'(digits));
    checkOutput({tag, ".running"}, 32'(Running), 32'(run));
    checkOutput({tag, ".alarm"}, 32'(Alarm), 32'(alarm));
  endtask

  // One rising edge with the given strobes, all strobes dropped afterwards.
  task automatic applyStimulus(input logic ld, input logic start, input logic stop, input logic tick);
    LD = ld; Start = start; Stop = stop; Tick = tick;
    @(posedge Clk);
    #1;
    LD = 1'b0; Start = 1'b0; Stop = 1'b0; Tick = 1'b0;
  endtask

  task automatic setPreset(input int mt, input int mu, input int st, input int su);
    IN_MT = 3'(mt); IN_MU = 4'(mu); IN_ST = 3'(st); IN_SU = 4'(su);
  endtask

  task automatic loadDigits(input int mt, input int mu, input int st, input int su);
    setPreset(mt, mu, st, su);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pulseClr();
    #2 Clr = 1'b0;
    #1;
    checkState("clrAsync", bcd(0, 0, 0, 0), 1'b0, 1'b0);
    #1 Clr = 1'b1;
  endtask

  initial begin
    Clr = 1'b0; Tick = 1'b0; LD = 1'b0; Start = 1'b0; Stop = 1'b0;
    setPreset(0, 0, 0, 0);
    #1;
    checkState("reset", bcd(0, 0, 0, 0), 1'b0, 1'b0);
    #12 Clr = 1'b1;
    @(posedge Clk);
    #1;

    // Abort a run at 05:17 with an asynchronous clear
    loadDigits(0, 5, 1, 7);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkState("run0517", bcd(0, 5, 1, 7), 1'b1, 1'b0);
    pulseClr();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkState("afterClrTick", bcd(0, 0, 0, 0), 1'b0, 1'b0);

    // 01:00 down to zero
    loadDigits(0, 1, 0, 0);
    checkState("load0100", bcd(0, 1, 0, 0), 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkState("first0059", bcd(0, 0, 5, 9), 1'b1, 1'b0);
    for (int i = 0; i < 58; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkState("at0001", bcd(0, 0, 0, 1), 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkState("ring", bcd(0, 0, 0, 0), 1'b0, 1'b1);

    // Ring timeout after 3 ticks
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkState("ring2", bcd(0, 0, 0, 0), 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkState("ringDone", bcd(0, 0, 0, 0), 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkState("ringDoneIdle", bcd(0, 0, 0, 0), 1'b0, 1'b0);

    // Early exit from RING with Stop, then with LD
    loadDigits(0, 0, 0, 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkState("ringStopPre", bcd(0, 0, 0, 0), 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkState("ringStop", bcd(0, 0, 0, 0), 1'b0, 1'b0);
    loadDigits(0, 0, 0, 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    loadDigits(0, 3, 0, 4);
    checkState("ringLoad", bcd(0, 3, 0, 4), 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkState("idleStart", bcd(0, 3, 0, 4), 1'b1, 1'b0);

    // Pause at 10:00 with Stop+Tick, resume, borrow to 09:59
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    loadDigits(1, 0, 0, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    checkState("stopTick", bcd(1, 0, 0, 0), 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkState("pauseTicks", bcd(1, 0, 0, 0), 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    checkState("resumeEntry", bcd(1, 0, 0, 0), 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkState("borrow0959", bcd(0, 9, 5, 9), 1'b1, 1'b0);

    // Clamped preset, then LD ignored while running
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    loadDigits(7, 12, 6, 15);
    checkState("clamp", bcd(5, 9, 5, 9), 1'b0, 1'b0);
    loadDigits(3, 0, 0, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    setPreset(0, 5, 0, 5);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    checkState("ldInRun", bcd(2, 9, 5, 9), 1'b1, 1'b0);

    // Start at 00:00 does nothing; Start+Stop in PAUSE stays paused
    pulseClr();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkState("startZero", bcd(0, 0, 0, 0), 1'b0, 1'b0);
    loadDigits(0, 2, 0, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    checkState("startStop", bcd(0, 2, 0, 0), 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkState("stillPaused", bcd(0, 2, 0, 0), 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
